// File: rtl/serial_slave_port.sv
// Serial bus slave endpoint: shifts in address/write data, accesses local
// memory, shifts read data back out under a valid/ready handshake.
module serial_slave_port #(
  parameter int ADDR_WIDTH  = 12,
  parameter int DATA_WIDTH  = 8,
  parameter int MEM_DEPTH   = 4096,
  parameter int WAIT_CYCLES = 2
) (
  input  logic clk,
  input  logic rst,
  input  logic mode,
  input  logic wr_bus,
  input  logic master_valid,
  input  logic master_ready,
  output logic rd_bus,
  output logic slave_ready,
  output logic slave_valid
);

  localparam int MX1 = (ADDR_WIDTH > DATA_WIDTH) ? ADDR_WIDTH : DATA_WIDTH;
  localparam int MX  = (MX1 > WAIT_CYCLES) ? MX1 : WAIT_CYCLES;
  localparam int CW  = $clog2(MX + 1);
  localparam int IW  = (MEM_DEPTH > 1) ? $clog2(MEM_DEPTH) : 1;

  typedef enum logic [1:0] {ADDR, WDATA, WAIT, RDATA} state_t;

  state_t state, state_nxt;

  logic [CW-1:0]         cnt, wcnt;
  logic [ADDR_WIDTH-1:0] addr, addr_sh;
  logic [DATA_WIDTH-2:0] data;
  logic [DATA_WIDTH-1:0] data_sh, tx;
  logic                  wr_q;
  logic [IW-1:0]         idx, idx_sh;
  logic                  rx_go, tx_go;
  logic                  last_a, last_d, last_w, last_t;

  logic [DATA_WIDTH-1:0] mem [MEM_DEPTH];

  assign rx_go   = master_valid & slave_ready;
  assign tx_go   = slave_valid & master_ready;
  assign addr_sh = {addr[ADDR_WIDTH-2:0], wr_bus};
  assign data_sh = {data, wr_bus};
  assign idx     = IW'(int'(addr) % MEM_DEPTH);
  assign idx_sh  = IW'(int'(addr_sh) % MEM_DEPTH);
  assign last_a  = (cnt == CW'(ADDR_WIDTH - 1));
  assign last_d  = (cnt == CW'(DATA_WIDTH - 1));
  assign last_t  = last_d;
  assign last_w  = (wcnt == CW'(WAIT_CYCLES - 1));

  always_ff @(posedge clk) begin
    if (rst) state <= ADDR;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    unique case (state)
      ADDR: if (rx_go && last_a)
        state_nxt = mode ? WDATA :
                    (WAIT_CYCLES == 0) ? RDATA : WAIT;
      WDATA: if (rx_go && last_d)
        state_nxt = (WAIT_CYCLES == 0) ? ADDR : WAIT;
      WAIT: if (last_w)
        state_nxt = wr_q ? ADDR : RDATA;
      RDATA: if (tx_go && last_t)
        state_nxt = ADDR;
      default: state_nxt = ADDR;
    endcase
  end

  always_comb begin
    slave_ready = (state == ADDR) || (state == WDATA);
    slave_valid = (state == RDATA);
    rd_bus      = slave_valid & tx[DATA_WIDTH-1];
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt  <= '0;
      wcnt <= '0;
      addr <= '0;
      data <= '0;
      tx   <= '0;
      wr_q <= 1'b0;
    end else begin
      unique case (state)
        ADDR: if (rx_go) begin
          addr <= addr_sh;
          cnt  <= last_a ? '0 : cnt + 1'b1;
          if (last_a) begin
            wr_q <= mode;
            // zero-latency read: fetch using the address incl. final bit
            if (!mode && WAIT_CYCLES == 0) tx <= mem[idx_sh];
          end
        end
        WDATA: if (rx_go) begin
          data <= data_sh[DATA_WIDTH-2:0];
          cnt  <= last_d ? '0 : cnt + 1'b1;
        end
        WAIT: begin
          wcnt <= last_w ? '0 : wcnt + 1'b1;
          if (last_w && !wr_q) tx <= mem[idx];
        end
        RDATA: if (tx_go) begin
          tx  <= {tx[DATA_WIDTH-2:0], 1'b0};
          cnt <= last_t ? '0 : cnt + 1'b1;
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (!rst && state == WDATA && rx_go && last_d)
      mem[idx] <= data_sh;
  end

endmodule

// File: tb/tb_serial_slave_port.sv
// Directed bench for serial_slave_port: default instance plus a
// MEM_DEPTH=16 / WAIT_CYCLES=0 instance sharing the same stimulus.
module tb_serial_slave_port;

  logic clk = 1'b0;
  logic rst, md, wb, mv, mr;
  logic rd_a, sr_a, sv_a, rd_b, sr_b, sv_b;
  logic sel;
  logic rd, sr, sv;
  int   n_chk = 0;
  int   n_err = 0;

  always #5 clk = ~clk;

  assign rd = sel ? rd_b : rd_a;
  assign sr = sel ? sr_b : sr_a;
  assign sv = sel ? sv_b : sv_a;

  serial_slave_port dut_a (
    .clk(clk), .rst(rst), .mode(md), .wr_bus(wb),
    .master_valid(mv), .master_ready(mr),
    .rd_bus(rd_a), .slave_ready(sr_a), .slave_valid(sv_a)
  );

  serial_slave_port #(.MEM_DEPTH(16), .WAIT_CYCLES(0)) dut_b (
    .clk(clk), .rst(rst), .mode(md), .wr_bus(wb),
    .master_valid(mv), .master_ready(mr),
    .rd_bus(rd_b), .slave_ready(sr_b), .slave_valid(sv_b)
  );

  task automatic check(input string tag,
                       input logic [31:0] got,
                       input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic idle(input int n);
    mv = 1'b0;
    repeat (n) @(negedge clk);
  endtask

  task automatic rx_bit(input logic b);
    int n = 0;
    mv = 1'b1;
    wb = b;
    while (!sr && n < 50) begin
      @(negedge clk);
      n++;
    end
    if (n >= 50) check("rx_timeout", 1, 0);
    @(negedge clk);
  endtask

  task automatic send_addr(input logic [11:0] a, input logic m,
                           input int gap);
    md = m;
    for (int i = 11; i >= 0; i--) begin
      if (gap > 0 && i != 11) idle(gap);
      rx_bit(a[i]);
    end
  endtask

  task automatic wr_txn(input logic [11:0] a, input logic [7:0] d,
                        input int gap, input int wc);
    send_addr(a, 1'b1, gap);
    for (int i = 7; i >= 0; i--) rx_bit(d[i]);
    mv = 1'b1;
    wb = 1'b1;
    for (int i = 0; i < wc; i++) begin
      check("wait_ready_low", 32'(sr), 0);
      @(negedge clk);
    end
    mv = 1'b0;
    check("ready_after_wr", 32'(sr), 1);
  endtask

  task automatic rd_txn(input logic [11:0] a, input int gap,
                        input logic [3:0] pat,
                        output logic [7:0] w, output int lat,
                        output int herr);
    int   n = 0;
    int   bits = 0;
    logic hold = 1'b0;
    logic hbit = 1'b0;
    w = '0;
    lat = 0;
    herr = 0;
    send_addr(a, 1'b0, gap);
    mv = 1'b0;
    while (bits < 8 && n < 100) begin
      mr = pat[n % 4];
      if (hold && rd !== hbit) herr++;
      hold = 1'b0;
      if (sv) begin
        if (mr) begin
          w = {w[6:0], rd};
          bits++;
        end else begin
          hold = 1'b1;
          hbit = rd;
        end
      end else if (bits == 0) begin
        lat++;
      end
      @(negedge clk);
      n++;
    end
    mr = 1'b0;
    if (n >= 100) check("rd_timeout", 1, 0);
    check("rd_valid_drop", 32'(sv), 0);
    check("rd_ready_back", 32'(sr), 1);
    check("rd_bus_idle", 32'(rd), 0);
  endtask

  task automatic pulse_rst();
    rst = 1'b1;
    mv  = 1'b0;
    mr  = 1'b0;
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;
  endtask

  logic [7:0] w;
  int lat, herr;

  initial begin
    sel = 1'b0;
    md = 1'b0; wb = 1'b0; mv = 1'b0; mr = 1'b0;
    @(negedge clk);
    pulse_rst();
    check("rst_ready", 32'(sr), 1);
    check("rst_valid", 32'(sv), 0);
    check("rst_rd_bus", 32'(rd), 0);

    wr_txn(12'h005, 8'hA5, 0, 2);
    rd_txn(12'h005, 0, 4'b1111, w, lat, herr);
    check("t1_data", 32'(w), 32'hA5);
    check("t1_latency", lat, 2);

    rd_txn(12'h005, 0, 4'b1001, w, lat, herr);
    check("t2_data", 32'(w), 32'hA5);
    check("t2_hold", herr, 0);

    wr_txn(12'h006, 8'h5A, 3, 2);
    rd_txn(12'h006, 3, 4'b1111, w, lat, herr);
    check("t3_data", 32'(w), 32'h5A);
    check("t3_latency", lat, 2);

    wr_txn(12'h010, 8'h3C, 0, 2);
    send_addr(12'h010, 1'b1, 0);
    for (int i = 7; i >= 4; i--) rx_bit(1'b1);
    pulse_rst();
    check("t4_ready", 32'(sr), 1);
    check("t4_valid", 32'(sv), 0);
    check("t4_rd_bus", 32'(rd), 0);
    rd_txn(12'h010, 0, 4'b1111, w, lat, herr);
    check("t4_data", 32'(w), 32'h3C);
    rd_txn(12'h005, 0, 4'b1111, w, lat, herr);
    check("t4_other", 32'(w), 32'hA5);

    sel = 1'b1;
    pulse_rst();
    check("b_rst_ready", 32'(sr), 1);
    wr_txn(12'h013, 8'h77, 0, 0);
    rd_txn(12'h003, 0, 4'b1111, w, lat, herr);
    check("t5_alias", 32'(w), 32'h77);
    check("t5_latency", lat, 0);

    wr_txn(12'h00A, 8'h9C, 0, 0);
    rd_txn(12'h00A, 0, 4'b1111, w, lat, herr);
    check("t6_data", 32'(w), 32'h9C);
    check("t6_latency", lat, 0);
    rd_txn(12'h013, 0, 4'b1111, w, lat, herr);
    check("t6_prev", 32'(w), 32'h77);

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_err);
    $finish;
  end

endmodule
